alu_cmd_driver: RTL and testbench
=================================

Name: alu_cmd_driver

Overview:
- Initiator side of the 8-bit ALU operand/opcode interface.
- Accepts operation commands (A, B, 4-bit op) over a valid/ready handshake and buffers them in a small FIFO.
- Drives each command onto the ALU inputs and waits out the ALU's registered output latency.
- Captures alu_out and returns it, with its opcode tag, over a second valid/ready handshake.
- Sits between a controller/testbench sequencer and the ALU; one command is in flight at a time.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, ≥2).
- ALU_LAT, 1, ALU clock edges from inputs stable to alu_out valid (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept.
- cmd_a  input  8  operand A.
- cmd_b  input  8  operand B.
- cmd_op  input  4  ALU select s[3:0].
- alu_a  output  8  to ALU A.
- alu_b  output  8  to ALU B.
- alu_s  output  4  to ALU s.
- alu_out  input  8  registered ALU result.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  8  captured result.
- rsp_op  output  4  opcode of that result.
- busy  output  1  FIFO non-empty or op in flight.
- op_count  output  16  completed responses, wraps at 16'hFFFF→0.

Behaviour:
- Reset (reset=0, async): all outputs/registers 0, FIFO empty, state IDLE. cmd_ready rises the first cycle after reset deasserts.
- Reset mid-operation: the in-flight op and buffered commands are discarded; no response is produced.
- cmd_ready = (fifo_count != DEPTH), combinational from the registered count.
- Push occurs on an edge with cmd_valid & cmd_ready.
- No bypass: a command pushed at edge E is not popped before edge E+1.
- FSM states: IDLE, WAIT, RESP.
- IDLE: when fifo_count != 0 at an edge:
  - pop head;
  - alu_a/alu_b/alu_s <= head;
  - tag_op <= head op;
  - cnt <= ALU_LAT;
  - go WAIT.
- WAIT:
  - cnt != 0: cnt decrements.
  - cnt == 0: rsp_data <= alu_out, rsp_op <= tag_op, rsp_valid <= 1, op_count++, go RESP.
- RESP: rsp_valid, rsp_data and rsp_op are held stable until rsp_ready. On the handshake edge:
  - rsp_valid <= 0;
  - if fifo_count != 0 at that edge, the next head is popped and loaded in the same edge (go WAIT);
  - otherwise go IDLE.
- alu_a/alu_b/alu_s change only on pop edges; they hold their values in IDLE, WAIT and RESP.
- Latency, ALU_LAT=1, empty FIFO: command accepted at edge E → ALU inputs at E+1 → rsp_valid high after E+3.
- Throughput with rsp_ready=1: one response every ALU_LAT+2 cycles.
- Simultaneous push and pop: both occur; count unchanged; FIFO pointers wrap modulo DEPTH.
- Full FIFO: cmd_ready=0; cmd_valid is ignored and nothing is overwritten.
- Push while in WAIT/RESP: allowed.
- busy = (state != IDLE) | (fifo_count != 0).
- Response order equals command order.

Test Plan:
- Bench ALU stub registers alu_a+alu_b each edge (ALU_LAT=1).
- Single op: after reset, push A=8'h12 B=8'h34 op=4'h0 at edge 1, rsp_ready=1 → rsp_valid high after edge 4 for one cycle, rsp_data=8'h46, rsp_op=4'h0, op_count=1.
- Backpressure: push 5 commands with rsp_ready=0 → 1 popped plus 4 buffered, cmd_ready=0 on the 6th attempt. rsp_data holds its value while stalled. Releasing rsp_ready yields 5 responses in order, spaced 3 cycles apart.
- Streaming: push on every cmd_ready, rsp_ready=1, ops A=i B=1 for i=0..7 → rsp_data = 1..8 in order, no drops or duplicates.
- Simultaneous push and pop at fifo_count=DEPTH-1 → count stays DEPTH-1 and cmd_ready stays 1.
- Mid-op reset: assert reset in WAIT with 2 commands buffered → all outputs 0 immediately, busy=0, and no response after release.
- Counter wrap: preload or force op_count=16'hFFFF, complete one op → op_count=16'h0000.

Source files
------------

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: buffers ALU commands in a FIFO, drives them onto the ALU one at a time, returns tagged results
// Ports: clk, reset (async, active-low); cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op command in;
//        alu_a/alu_b/alu_s to ALU, alu_out from ALU; rsp_valid/rsp_ready/rsp_data/rsp_op result out;
//        busy (work pending), op_count (completed responses, wrapping).
module alu_cmd_driver #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [3:0]  cmd_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_s,
  input  logic [7:0]  alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic [3:0]  rsp_op,
  output logic        busy,
  output logic [15:0] op_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ALU_LAT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t          state_q, state_d;
  logic [19:0]     mem_q [DEPTH];
  logic [19:0]     mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      tag_q, tag_d;
  logic [7:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_data_q, rsp_data_d;
  logic [3:0]      alu_s_q, alu_s_d, rsp_op_q, rsp_op_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [15:0]     op_count_q, op_count_d;
  // holds cmd_ready low through reset and rises on the first edge after release
  logic            rdy_q;
  logic            push, pop;
  logic [19:0]     head;
  assign cmd_ready = rdy_q & (count_q != (AW+1)'(DEPTH));
  assign busy      = (state_q != IDLE) | (count_q != '0);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_op    = rsp_op_q;
  assign op_count  = op_count_q;
  assign head      = mem_q[rd_ptr_q];
  // pop uses the registered count, so a command pushed this edge waits at least one more edge
  assign push = cmd_valid & cmd_ready;
  assign pop  = (count_q != '0) & ((state_q == IDLE) | ((state_q == RESP) & rsp_ready));
  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    tag_d       = tag_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_s_d     = alu_s_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_op_d    = rsp_op_q;
    op_count_d  = op_count_q;
    count_d     = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    if (push) begin
      mem_d[wr_ptr_q] = {cmd_a, cmd_b, cmd_op};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (state_q == WAIT) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        rsp_data_d  = alu_out;
        rsp_op_d    = tag_q;
        rsp_valid_d = 1'b1;
        op_count_d  = op_count_q + 16'd1;
        state_d     = RESP;
      end
    end
    if ((state_q == RESP) && rsp_ready) begin
      rsp_valid_d = 1'b0;
      state_d     = IDLE;
    end
    // a pop overrides the IDLE return above so back-to-back responses lose no cycle
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      alu_a_d  = head[19:12];
      alu_b_d  = head[11:4];
      alu_s_d  = head[3:0];
      tag_d    = head[3:0];
      cnt_d    = CW'(ALU_LAT);
      state_d  = WAIT;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cnt_q       <= '0;
      tag_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_op_q    <= '0;
      op_count_q  <= '0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cnt_q       <= cnt_d;
      tag_q       <= tag_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_s_q     <= alu_s_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_op_q    <= rsp_op_d;
      op_count_q  <= op_count_d;
      rdy_q       <= 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: directed self-checking bench for alu_cmd_driver with an adder ALU stub
module tb_alu_cmd_driver;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic [3:0]  cmd_op = '0;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_s;
  logic [7:0]  alu_out = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic [3:0]  rsp_op;
  logic        busy;
  logic [15:0] op_count;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) alu_out <= alu_a + alu_b;
  alu_cmd_driver #(.DEPTH(4), .ALU_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_op(rsp_op),
    .busy(busy), .op_count(op_count)
  );
  task automatic do_reset();
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_reset();
    cmd_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready got %b exp 0", cmd_ready); end
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_chk++; if ({alu_a, alu_b, alu_s, rsp_data, rsp_op} !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", {alu_a, alu_b, alu_s, rsp_data, rsp_op}); end
    n_chk++; if (op_count !== 16'h0) begin n_fail++; $display("FAIL reset_op_count got %h exp 0", op_count); end
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_rise got %b exp 1", cmd_ready); end
  endtask
  task automatic test_single();
    do_reset();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_a = 8'h12; cmd_b = 8'h34; cmd_op = 4'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    n_chk++; if ({alu_a, alu_b, alu_s} !== 20'h12340) begin n_fail++; $display("FAIL single_alu_in got %h exp 12340", {alu_a, alu_b, alu_s}); end
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early2 got %b exp 0", rsp_valid); end
    @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early3 got %b exp 0", rsp_valid); end
    @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", rsp_valid); end
    n_chk++; if (rsp_data !== 8'h46) begin n_fail++; $display("FAIL single_data got %h exp 46", rsp_data); end
    n_chk++; if (rsp_op !== 4'h0) begin n_fail++; $display("FAIL single_op got %h exp 0", rsp_op); end
    n_chk++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL single_count got %0d exp 1", op_count); end
    @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop got %b exp 0", rsp_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy got %b exp 0", busy); end
  endtask
  task automatic test_backpressure();
    int got = 0;
    int last = 0;
    int cyc = 0;
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_%0d got %b exp 1", i, cmd_ready); end
      cmd_valid = 1'b1; cmd_a = 8'(16 * i); cmd_b = 8'(i + 1); cmd_op = 4'(i);
      @(negedge clk);
    end
    n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got %b exp 0", cmd_ready); end
    cmd_a = 8'hEE; cmd_b = 8'h01; cmd_op = 4'hF;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_chk++; if ({rsp_valid, rsp_data} !== 9'h101) begin n_fail++; $display("FAIL bp_hold got %h exp 101", {rsp_valid, rsp_data}); end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    while (got < 5 && cyc < 100) begin
      if (rsp_valid) begin
        e = 8'(16 * got + got + 1);
        n_chk++; if ({rsp_data, rsp_op} !== {e, 4'(got)}) begin n_fail++; $display("FAIL bp_rsp_%0d got %h exp %h", got, {rsp_data, rsp_op}, {e, 4'(got)}); end
        if (got > 0) begin
          n_chk++; if (cyc - last !== 3) begin n_fail++; $display("FAIL bp_spacing_%0d got %0d exp 3", got, cyc - last); end
        end
        last = cyc;
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    n_chk++; if (got !== 5) begin n_fail++; $display("FAIL bp_count got %0d exp 5", got); end
    repeat (6) begin
      @(negedge clk);
      n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_extra got %b exp 0", rsp_valid); end
    end
    n_chk++; if (op_count !== 16'd5) begin n_fail++; $display("FAIL bp_op_count got %0d exp 5", op_count); end
  endtask
  task automatic test_streaming();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    do_reset();
    rsp_ready = 1'b1;
    while (got < 8 && cyc < 200) begin
      if (rsp_valid) begin
        n_chk++; if ({rsp_data, rsp_op} !== {8'(got + 1), 4'(got)}) begin n_fail++; $display("FAIL stream_rsp_%0d got %h exp %h", got, {rsp_data, rsp_op}, {8'(got + 1), 4'(got)}); end
        got++;
      end
      cmd_valid = (sent < 8); cmd_a = 8'(sent); cmd_b = 8'h01; cmd_op = 4'(sent);
      if (cmd_valid && cmd_ready) sent++;
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    n_chk++; if (got !== 8) begin n_fail++; $display("FAIL stream_count got %0d exp 8", got); end
    repeat (6) begin
      @(negedge clk);
      n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stream_extra got %b exp 0", rsp_valid); end
    end
  endtask
  task automatic test_simul();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_a = 8'(i); cmd_b = 8'h02; cmd_op = 4'(i);
      @(negedge clk);
    end
    n_chk++; if ({rsp_valid, rsp_data} !== 9'h102) begin n_fail++; $display("FAIL simul_rsp got %h exp 102", {rsp_valid, rsp_data}); end
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL simul_pre_ready got %b exp 1", cmd_ready); end
    cmd_a = 8'h40; rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL simul_post_ready got %b exp 1", cmd_ready); end
    n_chk++; if (alu_a !== 8'h01) begin n_fail++; $display("FAIL simul_next_head got %h exp 01", alu_a); end
    cmd_valid = 1'b1; cmd_a = 8'h50;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL simul_then_full got %b exp 0", cmd_ready); end
  endtask
  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_a = 8'h20; cmd_b = 8'(i); cmd_op = 4'h5;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    n_chk++; if ({busy, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL midrst_pre got %b exp 10", {busy, rsp_valid}); end
    reset = 1'b0;
    #1;
    n_chk++; if ({busy, rsp_valid, cmd_ready} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags got %b exp 000", {busy, rsp_valid, cmd_ready}); end
    n_chk++; if ({alu_a, alu_b, alu_s, rsp_data, rsp_op, op_count} !== 48'h0) begin n_fail++; $display("FAIL midrst_data got %h exp 0", {alu_a, alu_b, alu_s, rsp_data, rsp_op, op_count}); end
    @(negedge clk);
    reset = 1'b1;
    rsp_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      n_chk++; if ({busy, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL midrst_after got %b exp 00", {busy, rsp_valid}); end
    end
  endtask
  task automatic test_counter_wrap();
    int cyc = 0;
    do_reset();
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    n_chk++; if (op_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got %h exp ffff", op_count); end
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_a = 8'hFF; cmd_b = 8'h02; cmd_op = 4'h9;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_chk++; if ({rsp_valid, rsp_data, rsp_op} !== 13'h1019) begin n_fail++; $display("FAIL wrap_rsp got %h exp 1019", {rsp_valid, rsp_data, rsp_op}); end
    n_chk++; if (op_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_count got %h exp 0000", op_count); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_simul();
    test_mid_reset();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
